// File: rtl/g9_mem_pkg.sv
// Shared state encoding, requester ids and default widths for the G9 data-memory arbiter.
package g9_mem_pkg;

    localparam int unsigned DMEM_SIZE    = 32;
    localparam int unsigned DMEM_AW      = 9;
    localparam int unsigned DMEM_MEM_LAT = 1;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_LDR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after last_grant, with wrap-around.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   rot;

    // rot[j] is the request of requester (last_grant + 1 + j) mod NREQ
    assign req_dbl = {req, req};
    assign rot     = NREQ'(req_dbl >> (32'(last_grant) + 32'd1));

    // Scan from the far end so the nearest candidate is the one that sticks
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                valid  = 1'b1;
                winner = IW'((32'(last_grant) + 32'(j) + 32'd1) % NREQ);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared G9 data memory.
// Optional ownership lock for read-modify-write sequences: define DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import g9_mem_pkg::*;
#(
    parameter int unsigned size    = DMEM_SIZE,
    parameter int unsigned AW      = DMEM_AW,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MEM_LAT = DMEM_MEM_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*size-1:0] req_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
    output logic                 locked,
`endif
    output logic [NREQ-1:0]      ack,
    output logic [size-1:0]      rdata,
    output logic                 busy,
    output logic [AW-1:0]        mem_address,
    output logic [size-1:0]      mem_write_data,
    output logic                 mem_write,
    output logic                 mem_read,
    input  logic [size-1:0]      mem_read_data
);

    localparam int unsigned   IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned   CW       = 2;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    arb_state_e      state_q;
    logic [IW-1:0]   last_grant_q;
    logic [IW-1:0]   win_id_q;
    logic            win_we_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] ack_q;
    logic [size-1:0] rdata_q;
    logic            busy_q;
    logic [AW-1:0]   mem_address_q;
    logic [size-1:0] mem_write_data_q;
    logic            mem_write_q;
    logic            mem_read_q;

    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [IW-1:0]   grant_idx_c;
    logic            grant_valid_c;
    logic            enter_resp_c;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

`ifdef DMEM_ARB_LOCK_EN
    logic locked_q;
    logic lock_hold_c;

    // While locked, last_grant_q is the owner; it keeps the port as long as it still asks with lock
    assign lock_hold_c   = locked_q & req[last_grant_q] & req_lock[last_grant_q];
    assign grant_valid_c = lock_hold_c | pick_valid;
    assign grant_idx_c   = lock_hold_c ? last_grant_q : pick_idx;
    assign locked        = locked_q;
`else
    assign grant_valid_c = pick_valid;
    assign grant_idx_c   = pick_idx;
`endif

    // Read data is captured on the edge that enters RESP so it is valid alongside ack
    assign enter_resp_c = ((state_q == ISSUE) && (MEM_LAT == 0)) ||
                          ((state_q == WAIT) && (cnt_q == CW'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            last_grant_q     <= LAST_RST;
            win_id_q         <= '0;
            win_we_q         <= 1'b0;
            cnt_q            <= '0;
            ack_q            <= '0;
            rdata_q          <= '0;
            busy_q           <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            locked_q         <= 1'b0;
`endif
        end else begin
            ack_q       <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;

            case (state_q)
                IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
                    if (!lock_hold_c) begin
                        locked_q <= 1'b0;
                    end
`endif
                    if (grant_valid_c) begin
                        win_id_q         <= grant_idx_c;
                        win_we_q         <= req_we[grant_idx_c];
                        last_grant_q     <= grant_idx_c;
                        mem_address_q    <= req_addr[32'(grant_idx_c) * AW +: AW];
                        mem_write_data_q <= req_wdata[32'(grant_idx_c) * size +: size];
                        mem_write_q      <= req_we[grant_idx_c];
                        mem_read_q       <= ~req_we[grant_idx_c];
                        busy_q           <= 1'b1;
                        state_q          <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CW'(MEM_LAT);
                    state_q <= (MEM_LAT == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef DMEM_ARB_LOCK_EN
                    locked_q <= req_lock[win_id_q];
`endif
                end
                default: state_q <= IDLE;
            endcase

            if (enter_resp_c) begin
                ack_q[win_id_q] <= 1'b1;
                if (!win_we_q) begin
                    rdata_q <= mem_read_data;
                end
            end
        end
    end

    assign ack            = ack_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: MEM_LAT=1 main instance plus MEM_LAT=0 and MEM_LAT=3 instances.
module tb_dmem_arbiter;
    import g9_mem_pkg::*;

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    exp_t sb_q[$];
    exp_t sb0_q[$];
    exp_t sb3_q[$];

    // main instance (MEM_LAT = 1)
    logic [1:0]  req, req_we, ack;
    logic [17:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rdata, mem_write_data, mem_read_data;
    logic        busy, mem_write, mem_read;
    logic [8:0]  mem_address;
    // MEM_LAT = 0 instance
    logic [1:0]  l0_req, l0_we, l0_ack;
    logic [17:0] l0_addr;
    logic [63:0] l0_wdata;
    logic [31:0] l0_rdata, l0_mwd, l0_mrd;
    logic        l0_busy, l0_mw, l0_mr;
    logic [8:0]  l0_maddr;
    // MEM_LAT = 3 instance
    logic [1:0]  l3_req, l3_we, l3_ack;
    logic [17:0] l3_addr;
    logic [63:0] l3_wdata;
    logic [31:0] l3_rdata, l3_mwd, l3_mrd;
    logic        l3_busy, l3_mw, l3_mr;
    logic [8:0]  l3_maddr;
`ifdef DMEM_ARB_LOCK_EN
    logic [1:0]  req_lock;
    logic        locked, l0_locked, l3_locked;
`endif

    dmem_arbiter #(.size(32), .AW(9), .NREQ(2), .MEM_LAT(1)) u_dut (
        .clk(clk), .reset(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .req_lock(req_lock), .locked(locked),
`endif
        .ack(ack), .rdata(rdata), .busy(busy), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    dmem_arbiter #(.size(32), .AW(9), .NREQ(2), .MEM_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset_n), .req(l0_req), .req_we(l0_we), .req_addr(l0_addr),
        .req_wdata(l0_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .req_lock(2'b00), .locked(l0_locked),
`endif
        .ack(l0_ack), .rdata(l0_rdata), .busy(l0_busy), .mem_address(l0_maddr),
        .mem_write_data(l0_mwd), .mem_write(l0_mw), .mem_read(l0_mr),
        .mem_read_data(l0_mrd)
    );

    dmem_arbiter #(.size(32), .AW(9), .NREQ(2), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset_n), .req(l3_req), .req_we(l3_we), .req_addr(l3_addr),
        .req_wdata(l3_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .req_lock(2'b00), .locked(l3_locked),
`endif
        .ack(l3_ack), .rdata(l3_rdata), .busy(l3_busy), .mem_address(l3_maddr),
        .mem_write_data(l3_mwd), .mem_write(l3_mw), .mem_read(l3_mr),
        .mem_read_data(l3_mrd)
    );

    function automatic logic [31:0] init_word(input int unsigned a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Memory model: filled on the first edge; read data delayed by each instance's latency
    logic [31:0] tb_mem [0:511];
    logic        mem_init = 1'b0;
    logic [31:0] rd1_q, p1_q, p2_q, p3_q;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) tb_mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (mem_write) begin
            tb_mem[mem_address] <= mem_write_data;
        end
        rd1_q <= tb_mem[mem_address];
        p1_q  <= tb_mem[l3_maddr];
        p2_q  <= p1_q;
        p3_q  <= p2_q;
    end

    assign mem_read_data = rd1_q;
    assign l0_mrd        = tb_mem[l0_maddr];
    assign l3_mrd        = p3_q;

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (mem_address !== 9'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
        total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_write_data); end
`ifdef DMEM_ARB_LOCK_EN
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
`endif
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_load();
        exp_t e;
        int   n = 0;
        int   rd_pulses = 0;
        bit   done = 1'b0;
        @(negedge clk);
        req_addr[8:0] = 9'h010; req_we = 2'b00; req = 2'b01;
        e = '{ack: 2'b01, data: 32'hDEADBEEF, lat: 3};
        sb_q.push_back(e);
        while (!done && n < 20) begin
            @(negedge clk); n++;
            if (mem_read) rd_pulses++;
            if (n == 1) begin
                total++; if (mem_address !== 9'h010) begin bad++; $display("FAIL load_addr got=%h exp=010", mem_address); end
                total++; if ({busy, mem_write} !== 2'b10) begin bad++; $display("FAIL load_busy_we got=%b exp=10", {busy, mem_write}); end
            end
            if (ack !== 2'b00) begin
                done = 1'b1; req = 2'b00;
                if (sb_q.size() == 0) begin total++; bad++; $display("FAIL load_extra_ack got=%b", ack); end
                else begin
                    e = sb_q.pop_front();
                    total++; if (ack !== e.ack) begin bad++; $display("FAIL load_ack got=%b exp=%b", ack, e.ack); end
                    total++; if (rdata !== e.data) begin bad++; $display("FAIL load_rdata got=%h exp=%h", rdata, e.data); end
                    total++; if (n !== e.lat) begin bad++; $display("FAIL load_latency got=%0d exp=%0d", n, e.lat); end
                end
            end
        end
        total++; if (!done) begin bad++; $display("FAIL load_timeout got=no_ack exp=ack"); end
        @(negedge clk);
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL load_ack_pulse got=%b exp=00", ack); end
        total++; if (rd_pulses !== 1) begin bad++; $display("FAIL load_read_pulses got=%0d exp=1", rd_pulses); end
    endtask

    task automatic test_store_readback();
        exp_t e;
        int   n;
        int   wr_pulses = 0;
        int   wr_ok = 0;
        bit   done;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            if (t == 0) begin
                req_addr[17:9] = 9'h1FF; req_wdata[63:32] = 32'h0000_0005; req_we = 2'b10; req = 2'b10;
                e = '{ack: 2'b10, data: 32'hDEADBEEF, lat: 3};
            end else begin
                req_addr[8:0] = 9'h1FF; req_wdata[31:0] = 32'hFFFF_FFFF; req_we = 2'b00; req = 2'b01;
                e = '{ack: 2'b01, data: 32'h0000_0005, lat: 3};
            end
            sb_q.push_back(e);
            n = 0; done = 1'b0;
            while (!done && n < 20) begin
                @(negedge clk); n++;
                if (mem_write) begin
                    wr_pulses++;
                    if (mem_address === 9'h1FF && mem_write_data === 32'h5) wr_ok++;
                end
                if (ack !== 2'b00) begin
                    done = 1'b1; req = 2'b00;
                    if (sb_q.size() == 0) begin total++; bad++; $display("FAIL store_extra_ack got=%b", ack); end
                    else begin
                        e = sb_q.pop_front();
                        total++; if (ack !== e.ack) begin bad++; $display("FAIL store_ack%0d got=%b exp=%b", t, ack, e.ack); end
                        total++; if (rdata !== e.data) begin bad++; $display("FAIL store_rdata%0d got=%h exp=%h", t, rdata, e.data); end
                        total++; if (n !== e.lat) begin bad++; $display("FAIL store_latency%0d got=%0d exp=%0d", t, n, e.lat); end
                    end
                end
            end
            total++; if (!done) begin bad++; $display("FAIL store_timeout%0d got=no_ack exp=ack", t); end
        end
        total++; if (wr_pulses !== 1) begin bad++; $display("FAIL store_write_pulses got=%0d exp=1", wr_pulses); end
        total++; if (wr_ok !== 1) begin bad++; $display("FAIL store_write_payload got=%0d exp=1", wr_ok); end
    endtask

    task automatic test_contention();
        exp_t e;
        int   n = 0;
        int   acks = 0;
        int   busy_low = 0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        req_addr[8:0] = 9'h020; req_addr[17:9] = 9'h030; req_we = 2'b00; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            e = '{ack: (k % 2 == 0) ? 2'b01 : 2'b10,
                  data: init_word((k % 2 == 0) ? 32'h20 : 32'h30), lat: 3 + 4 * k};
            sb_q.push_back(e);
        end
        while (acks < 4 && n < 40) begin
            @(negedge clk); n++;
            if (!busy) busy_low++;
            if (ack !== 2'b00) begin
                acks++;
                if (acks == 4) req = 2'b00;
                if (sb_q.size() == 0) begin total++; bad++; $display("FAIL cont_extra_ack got=%b", ack); end
                else begin
                    e = sb_q.pop_front();
                    total++; if (ack !== e.ack) begin bad++; $display("FAIL cont_order%0d got=%b exp=%b", acks, ack, e.ack); end
                    total++; if (rdata !== e.data) begin bad++; $display("FAIL cont_rdata%0d got=%h exp=%h", acks, rdata, e.data); end
                    total++; if (n !== e.lat) begin bad++; $display("FAIL cont_latency%0d got=%0d exp=%0d", acks, n, e.lat); end
                end
            end
        end
        total++; if (acks !== 4) begin bad++; $display("FAIL cont_timeout got=%0d exp=4", acks); end
        total++; if (busy_low !== 3) begin bad++; $display("FAIL cont_busy_low got=%0d exp=3", busy_low); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n = 0;
        int   stray = 0;
        bit   done = 1'b0;
        @(negedge clk);
        req_addr[8:0] = 9'h040; req_we = 2'b00; req = 2'b01;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if ({busy, mem_read, mem_write} !== 3'b000) begin bad++; $display("FAIL mid_ctrl got=%b exp=000", {busy, mem_read, mem_write}); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
        total++; if (mem_address !== 9'h0) begin bad++; $display("FAIL mid_addr got=%h exp=0", mem_address); end
        req = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ack !== 2'b00) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL mid_stray_ack got=%0d exp=0", stray); end
        req_addr[8:0] = 9'h050; req_addr[17:9] = 9'h060; req = 2'b11;
        e = '{ack: 2'b01, data: init_word(32'h50), lat: 3};
        sb_q.push_back(e);
        while (!done && n < 20) begin
            @(negedge clk); n++;
            if (ack !== 2'b00) begin
                done = 1'b1; req = 2'b00;
                if (sb_q.size() == 0) begin total++; bad++; $display("FAIL mid_extra_ack got=%b", ack); end
                else begin
                    e = sb_q.pop_front();
                    total++; if (ack !== e.ack) begin bad++; $display("FAIL mid_first_grant got=%b exp=%b", ack, e.ack); end
                    total++; if (rdata !== e.data) begin bad++; $display("FAIL mid_rdata_after got=%h exp=%h", rdata, e.data); end
                end
            end
        end
        total++; if (!done) begin bad++; $display("FAIL mid_timeout got=no_ack exp=ack"); end
        @(negedge clk);
    endtask

    task automatic test_mem_lat();
        exp_t        e;
        int          n;
        int          writes = 0;
        bit          got0, got3;
        logic [31:0] wd0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            l0_we = 2'b00; l3_we = 2'b00;
            if (r == 0) begin
                l0_addr[8:0] = 9'h070; l3_addr[8:0] = 9'h080; l0_wdata[31:0] = 32'h1111_0000; wd0 = 32'h1111_0000;
                l0_req = 2'b01; l3_req = 2'b01;
                e = '{ack: 2'b01, data: init_word(32'h70), lat: 2}; sb0_q.push_back(e);
                e = '{ack: 2'b01, data: init_word(32'h80), lat: 5}; sb3_q.push_back(e);
            end else begin
                l0_addr[17:9] = 9'h090; l3_addr[17:9] = 9'h0A0; l0_wdata[63:32] = 32'h2222_0000; wd0 = 32'h2222_0000;
                l0_req = 2'b10; l3_req = 2'b10;
                e = '{ack: 2'b10, data: init_word(32'h90), lat: 2}; sb0_q.push_back(e);
                e = '{ack: 2'b10, data: init_word(32'hA0), lat: 5}; sb3_q.push_back(e);
            end
            n = 0; got0 = 1'b0; got3 = 1'b0;
            while ((!got0 || !got3) && n < 20) begin
                @(negedge clk); n++;
                if (l0_mw || l3_mw) writes++;
                if (n == 1) begin
                    total++; if (l0_mwd !== wd0) begin bad++; $display("FAIL lat0_wdata_latch got=%h exp=%h", l0_mwd, wd0); end
                    total++; if ({l0_busy, l0_mr, l3_busy, l3_mr} !== 4'b1111) begin bad++; $display("FAIL lat_issue got=%b exp=1111", {l0_busy, l0_mr, l3_busy, l3_mr}); end
                end
                if (l0_ack !== 2'b00) begin
                    got0 = 1'b1; l0_req = 2'b00;
                    if (sb0_q.size() == 0) begin total++; bad++; $display("FAIL lat0_extra_ack got=%b", l0_ack); end
                    else begin
                        e = sb0_q.pop_front();
                        total++; if (l0_ack !== e.ack) begin bad++; $display("FAIL lat0_ack%0d got=%b exp=%b", r, l0_ack, e.ack); end
                        total++; if (l0_rdata !== e.data) begin bad++; $display("FAIL lat0_rdata%0d got=%h exp=%h", r, l0_rdata, e.data); end
                        total++; if (n !== e.lat) begin bad++; $display("FAIL lat0_latency%0d got=%0d exp=%0d", r, n, e.lat); end
                    end
                end
                if (l3_ack !== 2'b00) begin
                    got3 = 1'b1; l3_req = 2'b00;
                    if (sb3_q.size() == 0) begin total++; bad++; $display("FAIL lat3_extra_ack got=%b", l3_ack); end
                    else begin
                        e = sb3_q.pop_front();
                        total++; if (l3_ack !== e.ack) begin bad++; $display("FAIL lat3_ack%0d got=%b exp=%b", r, l3_ack, e.ack); end
                        total++; if (l3_rdata !== e.data) begin bad++; $display("FAIL lat3_rdata%0d got=%h exp=%h", r, l3_rdata, e.data); end
                        total++; if (n !== e.lat) begin bad++; $display("FAIL lat3_latency%0d got=%0d exp=%0d", r, n, e.lat); end
                    end
                end
            end
            total++; if (!(got0 && got3)) begin bad++; $display("FAIL lat_timeout%0d got=%b%b exp=11", r, got0, got3); end
        end
        total++; if (writes !== 0) begin bad++; $display("FAIL lat_write_strobe got=%0d exp=0", writes); end
        total++; if ({l3_mwd[31:16], l3_wdata[63:48]} === 32'hFFFF_FFFF) begin bad++; $display("FAIL lat3_wdata got=%h exp=not_ffff", l3_mwd); end
`ifdef DMEM_ARB_LOCK_EN
        total++; if ({l0_locked, l3_locked} !== 2'b00) begin bad++; $display("FAIL lat_locked got=%b exp=00", {l0_locked, l3_locked}); end
`endif
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        exp_t e;
        int   n = 0;
        int   acks = 0;
        int   k1 = -10;
        int   k2 = -10;
        @(negedge clk);
        req_addr[8:0] = 9'h0B0; req_addr[17:9] = 9'h0C0; req_we = 2'b00; req_lock = 2'b10; req = 2'b11;
        e = '{ack: 2'b10, data: init_word(32'hC0), lat: 3};  sb_q.push_back(e);
        e = '{ack: 2'b10, data: init_word(32'hC0), lat: 7};  sb_q.push_back(e);
        e = '{ack: 2'b01, data: init_word(32'hB0), lat: 11}; sb_q.push_back(e);
        while (acks < 3 && n < 40) begin
            @(negedge clk); n++;
            if (n == k1 + 1) begin
                total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_held got=%b exp=1", locked); end
            end
            if (n == k1 + 2) req_lock = 2'b00;
            if (n == k2 + 1) begin
                total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_released got=%b exp=0", locked); end
            end
            if (ack !== 2'b00) begin
                acks++;
                if (acks == 1) k1 = n;
                if (acks == 2) begin k2 = n; req = 2'b01; end
                if (acks == 3) req = 2'b00;
                if (sb_q.size() == 0) begin total++; bad++; $display("FAIL lock_extra_ack got=%b", ack); end
                else begin
                    e = sb_q.pop_front();
                    total++; if (ack !== e.ack) begin bad++; $display("FAIL lock_order%0d got=%b exp=%b", acks, ack, e.ack); end
                    total++; if (rdata !== e.data) begin bad++; $display("FAIL lock_rdata%0d got=%h exp=%h", acks, rdata, e.data); end
                    total++; if (n !== e.lat) begin bad++; $display("FAIL lock_latency%0d got=%0d exp=%0d", acks, n, e.lat); end
                end
            end
        end
        total++; if (acks !== 3) begin bad++; $display("FAIL lock_timeout got=%0d exp=3", acks); end
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        req       = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        l0_req    = 2'b00; l0_we  = 2'b00; l0_addr  = '0; l0_wdata  = '0;
        l3_req    = 2'b00; l3_we  = 2'b00; l3_addr  = '0; l3_wdata  = '0;
`ifdef DMEM_ARB_LOCK_EN
        req_lock  = 2'b00;
`endif
        test_reset();
        test_single_load();
        test_store_readback();
        test_contention();
        test_reset_mid();
        test_mem_lat();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Multi-cycle arbiter and sequencer for the shared G9 data memory.
- Serialises load/store transactions from NREQ requesters onto one data-memory port:
  - requester 0: processor core load/store path;
  - requester 1: program loader/debug port.
- Uses round-robin grant, a fixed per-transaction sequence (latch, issue, wait, respond) and a one-cycle acknowledge pulse per requester.
- Sits between the requesters and the DataMemory instance; drives its address, write data and write/read strobes.

Parameters:
- size, 32: data width in bits.
- AW, 9: memory address width (512 words).
- NREQ, 2: number of requesters (2..4).
- MEM_LAT, 1: memory read latency in cycles (0..3); the arbiter waits this long before sampling read data.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req, input, NREQ: per-requester request level; held until the matching ack.
- req_we, input, NREQ: per-requester write enable (1 = store, 0 = load).
- req_addr, input, NREQ*AW: packed addresses; requester i occupies bits [i*AW +: AW].
- req_wdata, input, NREQ*size: packed write data.
- ack, output, NREQ: one-cycle completion pulse, one bit per requester.
- rdata, output, size: load data; valid in the ack cycle and held until the next load completes.
- busy, output, 1: high whenever the FSM is not IDLE.
- mem_address, output, AW: address to data memory.
- mem_write_data, output, size: write data to data memory.
- mem_write, output, 1: memory write strobe.
- mem_read, output, 1: memory read strobe.
- mem_read_data, input, size: read data from memory.

Behaviour:
- Reset values (reset low, asynchronous):
  - state = IDLE;
  - ack = 0, mem_write = 0, mem_read = 0, busy = 0;
  - rdata = 0, mem_address = 0, mem_write_data = 0;
  - last_grant = NREQ-1, so requester 0 wins first;
  - wait counter = 0.
- Reset asserted mid-transaction:
  - the transaction is abandoned and no ack is produced;
  - a store strobe already issued may or may not have completed; the spec does not define this.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, choose the winner: the first requester with req set, searching from last_grant+1 with wrap-around.
  - Latch the winner's id, we, addr and wdata, update last_grant, and go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - drive mem_address and mem_write_data from the latches;
  - assert mem_write = we, mem_read = ~we;
  - load the counter with MEM_LAT;
  - next state is WAIT if MEM_LAT > 0, else RESP.
- WAIT:
  - strobes are low; address and data stay held;
  - decrement the counter each cycle and go to RESP when it reaches 1.
- RESP:
  - for a load, register mem_read_data into rdata;
  - pulse ack[winner] for exactly one cycle;
  - return to IDLE.
- Latency from the req-sampled cycle to the ack cycle is 2 + MEM_LAT cycles. Loads and stores have the same latency.
- Arbitration is evaluated only in IDLE. A requester that raises req mid-transaction waits; it is never pre-empted.
- Back-to-back requests: a requester that keeps req high after its ack is re-arbitrated in the next IDLE cycle. With both requesters always requesting, grants alternate strictly, so each waits at most one transaction.
- Requester drops req before its ack: protocol violation; the transaction still completes and ack still pulses.
- Simultaneous requests in IDLE are resolved by round-robin only; there is no fixed priority.
- Store rdata: rdata is unchanged after a store.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - add input req_lock [NREQ-1:0];
  - if the winner's req_lock bit is high in its RESP cycle, ownership is retained;
  - the next IDLE considers only that requester until it is seen in IDLE with req_lock low or req low, after which round-robin resumes from it;
  - add output locked, 1 bit, high while ownership is retained;
  - used for atomic read-modify-write sequences.
- Without the macro: no req_lock port and no locked port; pure round-robin.

Decomposition:
- Package g9_mem_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - requester id constants REQ_CPU=0 and REQ_LDR=1;
  - the default widths: size, AW, MEM_LAT.
- One sub-module, rr_pick: purely combinational round-robin priority picker.
  - Inputs: req and last_grant.
  - Outputs: winner index and a valid flag.
  - Instantiated once.

Test Plan:
- Single load: after reset, req=01, req_we=00, addr0=9'h010, memory holds 32'hDEADBEEF at 9'h010 → mem_read high for 1 cycle in ISSUE; ack=01 three cycles after the req-sampled cycle (MEM_LAT=1); rdata=32'hDEADBEEF.
- Single store: req=10, req_we=10, addr1=9'h1FF, wdata1=32'h00000005 → one mem_write pulse with mem_address=9'h1FF; ack=10 after 3 cycles; a following load of 9'h1FF returns 32'h00000005.
- Contention: req=11 held for 4 transactions from reset → acks in order 01, 10, 01, 10; busy stays high throughout apart from the single IDLE cycle between transactions.
- Reset mid-operation: assert reset low during WAIT → all outputs at reset values immediately (asynchronous); no ack afterwards; first grant after release goes to requester 0.
- MEM_LAT sweep: MEM_LAT=0 gives ack 2 cycles after the req-sampled cycle; MEM_LAT=3 gives 5 cycles; rdata correct in both.
- With DMEM_ARB_LOCK_EN: requester 1 issues 2 transactions with req_lock=1 while req0 is held high → both requester-1 transactions complete before any ack[0]; locked is high between them; requester 0 is granted next.
